// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, fetch FSM encoding and arbitration helper
package display_pkg;

    localparam int SRC_GAME   = 0;
    localparam int SRC_BANNER = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Banner has fixed priority over the live game view.
    function automatic logic [1:0] arbitrate(input logic [1:0] req);
        logic [1:0] g;
        g = 2'b00;
        if (req[SRC_BANNER])
            g = 2'b10;
        else if (req[SRC_GAME])
            g = 2'b01;
        return g;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to abcdefg.dp segment pattern, non-decimal codes blank
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_arbiter.sv
// rtl/display_scan_arbiter.sv - LED matrix / seven-seg scanner with frame-boundary source arbitration
module display_scan_arbiter
    import display_pkg::*;
#(
    parameter int ROW_TICKS    = 8192,
    parameter int FETCH_WINDOW = 64,
    parameter int BLANK_TICKS  = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  src_req,
    output logic [1:0]  src_grant,
    output logic        row_rd,
    output logic [2:0]  row_addr,
    input  logic [1:0]  src_valid,
    input  logic [7:0]  src0_r,
    input  logic [7:0]  src0_g,
    input  logic [7:0]  src1_r,
    input  logic [7:0]  src1_g,
    input  logic [23:0] digit_bcd,
    output logic [7:0]  matrix_segout_r,
    output logic [7:0]  matrix_segout_g,
    output logic [7:0]  matrix_scanout,
    output logic [7:0]  led_segout,
    output logic [2:0]  led_scanout,
    output logic        frame_start,
    output logic [7:0]  miss_cnt
);

    localparam int            TW          = $clog2(ROW_TICKS);
    localparam logic [TW-1:0] TICK_LAST   = TW'(ROW_TICKS - 1);
    localparam logic [TW-1:0] FETCH_START = TW'(ROW_TICKS - FETCH_WINDOW);
    localparam logic [TW-1:0] BLANK_END   = TW'(BLANK_TICKS);

    logic [TW-1:0] tick, tick_nxt;
    logic [2:0]    row, row_nxt, digit, digit_nxt;
    logic          wrap, fetch_edge, blank_nxt, valid_sel;
    logic [1:0]    grant_nxt;
    fetch_state_t  state, state_nxt;
    logic          start_fetch, take_data, missed;
    logic [7:0]    shadow_r, shadow_g, line_r, line_g, line_r_nxt, line_g_nxt;
    logic [7:0]    data_r, data_g, seg;
    logic [3:0]    nib, nib_nxt, digit_sel;

    // Everything registered is computed from next-cycle counter values so pins line up with tick.
    assign wrap       = (tick == TICK_LAST);
    assign tick_nxt   = wrap ? '0 : tick + TW'(1);
    assign row_nxt    = wrap ? row + 3'd1 : row;
    assign digit_nxt  = wrap ? ((digit == 3'd5) ? 3'd0 : digit + 3'd1) : digit;
    assign fetch_edge = (tick_nxt == FETCH_START);
    assign blank_nxt  = (tick_nxt < BLANK_END);

    // Only the row-7 fetch (next frame's row 0) may change ownership.
    assign grant_nxt  = (fetch_edge && row == 3'd7) ? arbitrate(src_req) : src_grant;
    assign valid_sel  = |(src_valid & src_grant);
    assign data_r     = src_grant[SRC_BANNER] ? src1_r : src0_r;
    assign data_g     = src_grant[SRC_BANNER] ? src1_g : src0_g;

    assign line_r_nxt = wrap ? shadow_r : line_r;
    assign line_g_nxt = wrap ? shadow_g : line_g;

    always_comb begin
        case (digit_nxt)
            3'd0:    digit_sel = digit_bcd[23:20];
            3'd1:    digit_sel = digit_bcd[19:16];
            3'd2:    digit_sel = digit_bcd[15:12];
            3'd3:    digit_sel = digit_bcd[11:8];
            3'd4:    digit_sel = digit_bcd[7:4];
            3'd5:    digit_sel = digit_bcd[3:0];
            default: digit_sel = 4'h0;
        endcase
    end

    assign nib_nxt = (tick_nxt == BLANK_END) ? digit_sel : nib;

    seg7_decode u_seg7_decode (
        .bcd (nib_nxt),
        .seg (seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fetch_edge && grant_nxt != 2'b00) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wrap)
                    state_nxt = ST_IDLE;
                else if (valid_sel)
                    state_nxt = ST_DONE;
            end
            ST_DONE: if (wrap) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_fetch = 1'b0;
        take_data   = 1'b0;
        missed      = 1'b0;
        case (state)
            ST_IDLE: start_fetch = fetch_edge && (grant_nxt != 2'b00);
            ST_WAIT: begin
                take_data = valid_sel && !wrap;
                missed    = wrap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick            <= '0;
            row             <= 3'd0;
            digit           <= 3'd0;
            nib             <= 4'h0;
            shadow_r        <= 8'h00;
            shadow_g        <= 8'h00;
            line_r          <= 8'h00;
            line_g          <= 8'h00;
            src_grant       <= 2'b00;
            row_rd          <= 1'b0;
            row_addr        <= 3'd0;
            frame_start     <= 1'b0;
            miss_cnt        <= 8'h00;
            matrix_scanout  <= 8'h00;
            matrix_segout_r <= 8'h00;
            matrix_segout_g <= 8'h00;
            led_segout      <= 8'h00;
            led_scanout     <= 3'd0;
        end else begin
            tick      <= tick_nxt;
            row       <= row_nxt;
            digit     <= digit_nxt;
            nib       <= nib_nxt;
            src_grant <= grant_nxt;
            line_r    <= line_r_nxt;
            line_g    <= line_g_nxt;
            // Shadow starts every fetch window empty so a miss or no-owner row shows dark.
            if (take_data) begin
                shadow_r <= data_r;
                shadow_g <= data_g;
            end else if (fetch_edge) begin
                shadow_r <= 8'h00;
                shadow_g <= 8'h00;
            end
            row_rd      <= start_fetch;
            row_addr    <= start_fetch ? row + 3'd1 : 3'd0;
            frame_start <= wrap && (row == 3'd7);
            if (missed && miss_cnt != 8'hFF)
                miss_cnt <= miss_cnt + 8'd1;
            matrix_scanout  <= blank_nxt ? 8'h00 : (8'h01 << row_nxt);
            matrix_segout_r <= blank_nxt ? 8'h00 : line_r_nxt;
            matrix_segout_g <= blank_nxt ? 8'h00 : line_g_nxt;
            led_segout      <= blank_nxt ? 8'h00 : seg;
            led_scanout     <= digit_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_arbiter.sv
// tb/tb_display_scan_arbiter.sv - scoreboard bench for display_scan_arbiter
module tb_display_scan_arbiter;

    localparam int RT = 32;
    localparam int FW = 8;
    localparam int BL = 2;
    localparam int FS = RT - FW;

    typedef struct {
        int         when;
        logic [7:0] r;
        logic [7:0] g;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  src_req = 2'b00;
    logic [1:0]  src_grant;
    logic        row_rd;
    logic [2:0]  row_addr;
    logic [1:0]  src_valid = 2'b00;
    logic [7:0]  src0_r = 8'h00;
    logic [7:0]  src0_g = 8'h00;
    logic [7:0]  src1_r = 8'hAA;
    logic [7:0]  src1_g = 8'h55;
    logic [23:0] digit_bcd = 24'h01234F;
    logic [7:0]  matrix_segout_r, matrix_segout_g, matrix_scanout, led_segout, miss_cnt;
    logic [2:0]  led_scanout;
    logic        frame_start;

    int   n_checks = 0;
    int   n_fail = 0;
    int   bt = 0, br = 0, bd = 0, gr = 0;
    int   exp_miss = 0;
    int   rsp_cnt = 0;
    logic [1:0] exp_grant = 2'b00;
    logic [1:0] req_arb = 2'b00;
    logic no_resp3 = 1'b0;
    logic late3 = 1'b0;
    exp_t sb[$];
    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    display_scan_arbiter #(.ROW_TICKS(RT), .FETCH_WINDOW(FW), .BLANK_TICKS(BL)) dut (
        .clk             (clk),
        .reset           (reset),
        .src_req         (src_req),
        .src_grant       (src_grant),
        .row_rd          (row_rd),
        .row_addr        (row_addr),
        .src_valid       (src_valid),
        .src0_r          (src0_r),
        .src0_g          (src0_g),
        .src1_r          (src1_r),
        .src1_g          (src1_g),
        .digit_bcd       (digit_bcd),
        .matrix_segout_r (matrix_segout_r),
        .matrix_segout_g (matrix_segout_g),
        .matrix_scanout  (matrix_scanout),
        .led_segout      (led_segout),
        .led_scanout     (led_scanout),
        .frame_start     (frame_start),
        .miss_cnt        (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (row %0d tick %0d)", tag, got, exp, br, bt);
        end
    endtask

    function automatic logic [1:0] exp_arb(input logic [1:0] req);
        if (req[1]) return 2'b10;
        if (req[0]) return 2'b01;
        return 2'b00;
    endfunction

    task automatic wait_pos(input int r, input int t);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (br == r && bt == t) return;
        end
        check("wait_timeout", 32'd1, 32'd0);
    endtask

    // Timing model: tick/row/digit as the scanner must see them.
    always @(posedge clk) begin
        if (!reset) begin
            bt = 0; br = 0; bd = 0; gr = 0;
        end else if (bt == RT - 1) begin
            bt = 0;
            br = (br + 1) % 8;
            bd = (bd == 5) ? 0 : bd + 1;
            gr++;
        end else begin
            bt++;
        end
    end

    // Frame sources plus output monitor.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] er, eg;
        logic       exp_rd, exp_fs, miss;
        logic [3:0] nib;
        if (!reset) begin
            rsp_cnt = 0;
            src_valid = 2'b00;
            exp_grant = 2'b00;
            exp_miss = 0;
            sb.delete();
        end else begin
            src_valid = 2'b00;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 1) src_valid = ~exp_grant;
                if (rsp_cnt == 0) src_valid = exp_grant;
            end
            if (bt == FS - 1 && br == 7) req_arb = src_req;
            if (bt == FS && br == 7) exp_grant = exp_arb(req_arb);
            exp_rd = (bt == FS) && (exp_grant != 2'b00);
            if (row_rd || exp_rd) begin
                check("row_rd", 32'(row_rd), 32'(exp_rd));
                check("row_addr", 32'(row_addr), (br + 1) % 8);
                check("grant_at_rd", 32'(src_grant), 32'(exp_grant));
            end
            if (exp_rd) begin
                miss = (br == 2) && (no_resp3 || late3);
                e.when = gr + 1;
                if (miss) begin
                    e.r = 8'h00; e.g = 8'h00;
                    exp_miss++;
                end else if (exp_grant == 2'b10) begin
                    e.r = 8'hAA; e.g = 8'h55;
                end else begin
                    e.r = 8'((br + 1) % 8); e.g = ~e.r;
                end
                sb.push_back(e);
                src0_r = 8'((br + 1) % 8);
                src0_g = ~src0_r;
                if (!(no_resp3 && br == 2)) rsp_cnt = (late3 && br == 2) ? 7 : 3;
            end
            if (bt < BL)
                check("blank", {matrix_scanout, matrix_segout_r, matrix_segout_g, led_segout}, 32'd0);
            if (bt == BL) begin
                er = 8'h00; eg = 8'h00;
                if (sb.size() > 0 && sb[0].when == gr) begin
                    e = sb.pop_front();
                    er = e.r; eg = e.g;
                end
                nib = 4'((digit_bcd >> (4 * (5 - bd))) & 24'hF);
                check("seg_r", 32'(matrix_segout_r), 32'(er));
                check("seg_g", 32'(matrix_segout_g), 32'(eg));
                check("scanout", 32'(matrix_scanout), 32'd1 << br);
                check("grant", 32'(src_grant), 32'(exp_grant));
                check("miss_cnt", 32'(miss_cnt), exp_miss);
                check("led_scan", 32'(led_scanout), bd);
                check("led_seg", 32'(led_segout), 32'(seg_tab[nib]));
            end
            exp_fs = (bt == 0 && br == 0 && gr > 0);
            if (frame_start || exp_fs)
                check("frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;

        // No owner: blank matrix, no fetch strobes.
        src_req = 2'b00;
        wait_pos(0, 0);
        wait_pos(0, 0);

        // Game source owns the matrix.
        src_req = 2'b01;
        repeat (3) wait_pos(0, 0);

        // Banner wins, then drops its request mid-frame.
        src_req = 2'b11;
        digit_bcd = 24'h56789A;
        wait_pos(0, 0);
        wait_pos(3, 0);
        src_req = 2'b01;
        wait_pos(0, 0);
        wait_pos(0, 0);

        // Row 3 data never arrives, then arrives exactly on the boundary.
        digit_bcd = 24'h01234F;
        no_resp3 = 1'b1;
        wait_pos(0, 0);
        wait_pos(0, 0);
        no_resp3 = 1'b0;
        late3 = 1'b1;
        wait_pos(0, 0);
        late3 = 1'b0;
        wait_pos(0, 0);

        // Reset while waiting on row 6 data.
        wait_pos(5, FS + 2);
        reset = 1'b0;
        #1;
        check("reset_matrix", {matrix_scanout, matrix_segout_r, matrix_segout_g, led_segout}, 32'd0);
        check("reset_ctrl", 32'({led_scanout, frame_start, row_rd, row_addr, src_grant, miss_cnt}), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        wait_pos(0, 0);
        wait_pos(0, 0);
        wait_pos(4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
